// File: rtl/axi4w_arbiter_if.sv
// Multi-lane AXI4 write-channel bundle (AW, W, B); lane i of every field occupies slice i.
// Handshake rule for every channel: a transfer happens on the rising clk edge where valid && ready are both high; once valid rises, it and its payload stay stable until that edge.
interface axi4w_arbiter_if #(
  parameter int NM = 1
);
  logic [NM-1:0]    awvalid;
  logic [NM-1:0]    awready;
  logic [NM*32-1:0] awaddr;
  logic [NM*4-1:0]  awid;
  logic [NM*8-1:0]  awlen;
  logic [NM*3-1:0]  awsize;
  logic [NM*2-1:0]  awburst;
  logic [NM-1:0]    wvalid;
  logic [NM-1:0]    wready;
  logic [NM*64-1:0] wdata;
  logic [NM*8-1:0]  wstrb;
  logic [NM-1:0]    wlast;
  logic [NM-1:0]    bvalid;
  logic [NM-1:0]    bready;
  logic [NM*2-1:0]  bresp;
  logic [NM*4-1:0]  bid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/axi4w_arbiter.sv
// Round-robin arbiter letting N AXI4 write masters share one slave, one transaction at a time.
// The burst length is taken from awlen, so s.wlast is generated here rather than forwarded.
module axi4w_arbiter #(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  axi4w_arbiter_if.slave  m,
  axi4w_arbiter_if.master s,
  output logic            busy,
  output logic [GW-1:0]   grant,
  output logic            err_wlast,
  output logic [1:0]      dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] last;
  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  logic [7:0]    cnt;
  logic          any_req, aw_hs, w_hs, b_hs, final_beat;

  assign any_req    = |m.awvalid;
  assign final_beat = (cnt == 8'd0);
  assign aw_hs      = (state == ADDR) && m.awvalid[grant] && s.awready;
  assign w_hs       = (state == DATA) && m.wvalid[grant] && s.wready;
  assign b_hs       = (state == RESP) && s.bvalid && m.bready[grant];
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  // Scan downward so the nearest requester after 'last' is the one that sticks.
  always_comb begin
    pick = last;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = GW'((int'(last) + k) % N);
      if (m.awvalid[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ADDR;
      ADDR:    if (aw_hs) state_nx = DATA;
      DATA:    if (w_hs && final_beat) state_nx = RESP;
      RESP:    if (b_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      last      <= GW'(N - 1);
      cnt       <= 8'd0;
      err_wlast <= 1'b0;
    end else begin
      if (state == IDLE && any_req) grant <= pick;
      if (aw_hs) cnt <= s.awlen;
      else if (w_hs && !final_beat) cnt <= cnt - 8'd1;
      if (w_hs && (m.wlast[grant] != final_beat)) err_wlast <= 1'b1;
      if (b_hs) last <= grant;
    end
  end

  // Payload follows the owner at all times; only valid/ready are gated by state.
  always_comb begin
    s.awvalid = 1'b0;
    s.awaddr  = '0;
    s.awid    = '0;
    s.awlen   = '0;
    s.awsize  = '0;
    s.awburst = '0;
    s.wvalid  = 1'b0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wlast   = (state == DATA) && final_beat;
    s.bready  = 1'b0;
    m.awready = '0;
    m.wready  = '0;
    m.bvalid  = '0;
    m.bresp   = {N{s.bresp}};
    m.bid     = {N{s.bid}};
    for (int i = 0; i < N; i++) begin
      if (grant == GW'(i)) begin
        s.awaddr  = m.awaddr[i*32 +: 32];
        s.awid    = m.awid[i*4 +: 4];
        s.awlen   = m.awlen[i*8 +: 8];
        s.awsize  = m.awsize[i*3 +: 3];
        s.awburst = m.awburst[i*2 +: 2];
        s.wdata   = m.wdata[i*64 +: 64];
        s.wstrb   = m.wstrb[i*8 +: 8];
        case (state)
          ADDR: begin
            s.awvalid    = m.awvalid[i];
            m.awready[i] = s.awready;
          end
          DATA: begin
            s.wvalid    = m.wvalid[i];
            m.wready[i] = s.wready;
          end
          RESP: begin
            m.bvalid[i] = s.bvalid;
            s.bready    = m.bready[i];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axi4w_arbiter.sv
// Bench for axi4w_arbiter: random masters and slave, a transaction-level owner model checked
// every cycle, a per-master beat scoreboard, and directed scenarios with literal expectations.
module tb_axi4w_arbiter;
  localparam int N = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4w_arbiter_if #(.NM(N)) m_if ();
  axi4w_arbiter_if #(.NM(1)) s_if ();
  logic       busy;
  logic [0:0] grant;
  logic       err_wlast;
  logic [1:0] dbg_state;

  axi4w_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .m(m_if), .s(s_if),
    .busy(busy), .grant(grant), .err_wlast(err_wlast), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [63:0] exp_q [N][$];

  // stimulus knobs
  int aw_rate, w_rate, br_rate, saw_rate, sw_rate, len_force, len_max, bad_beat, aw_stall;
  bit w_toggle, use_bid;
  logic [3:0] force_bid;

  // bench master/slave state
  int mph[N], mpend[N], mlen[N], mbeat[N];
  bit sb_pend;
  bit hs_aw[N], hs_w[N], hs_b[N];
  bit shs_w_last, shs_b;

  // reference model: owner of the slave and progress of its transaction
  int own, ph, beats_left, cur_len, last_m;
  bit err_m;
  int grant_log[$];

  // scenario monitors
  int sc_beats, sc_last_cnt, sc_last_idx, viol1, bv0_cnt;
  bit saw_bv0, saw_bv1;
  logic [3:0] bid1_cap;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int urand(int lo, int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic int rr_pick(logic [N-1:0] req, int lst);
    for (int k = 1; k <= N; k++)
      if (req[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  // ---------------- compare + model (negedge) ----------------
  task automatic model_step();
    logic [N-1:0] e_awr, e_wr, e_bv;
    logic e_sawv, e_swv, e_sbr;
    e_awr = '0; e_wr = '0; e_bv = '0;
    e_sawv = 1'b0; e_swv = 1'b0; e_sbr = 1'b0;
    chk("busy", busy, own >= 0);
    chk("err_wlast", err_wlast, err_m);
    if (own >= 0) begin
      chk("grant", grant, own);
      case (ph)
        1: begin
          e_awr[own] = s_if.awready;
          e_sawv = m_if.awvalid[own];
          chk("awaddr", s_if.awaddr, m_if.awaddr[own*32 +: 32]);
          chk("awid", s_if.awid, m_if.awid[own*4 +: 4]);
          chk("awlen", s_if.awlen, m_if.awlen[own*8 +: 8]);
          chk("awsize", s_if.awsize, m_if.awsize[own*3 +: 3]);
          chk("awburst", s_if.awburst, m_if.awburst[own*2 +: 2]);
        end
        2: begin
          e_wr[own] = s_if.wready;
          e_swv = m_if.wvalid[own];
          chk("wdata", s_if.wdata, m_if.wdata[own*64 +: 64]);
          chk("wstrb", s_if.wstrb, m_if.wstrb[own*8 +: 8]);
          chk("s_wlast", s_if.wlast, beats_left == 1);
        end
        default: begin
          e_bv[own] = s_if.bvalid;
          e_sbr = m_if.bready[own];
          chk("bid", m_if.bid[own*4 +: 4], s_if.bid);
          chk("bresp", m_if.bresp[own*2 +: 2], s_if.bresp);
        end
      endcase
    end
    chk("m_awready", m_if.awready, e_awr);
    chk("m_wready", m_if.wready, e_wr);
    chk("m_bvalid", m_if.bvalid, e_bv);
    chk("s_awvalid", s_if.awvalid, e_sawv);
    chk("s_wvalid", s_if.wvalid, e_swv);
    chk("s_bready", s_if.bready, e_sbr);

    if (own == 0 && (m_if.awready[1] || m_if.wready[1] || m_if.bvalid[1])) viol1++;
    if (m_if.bvalid[0]) begin saw_bv0 = 1'b1; bv0_cnt++; end
    if (m_if.bvalid[1]) saw_bv1 = 1'b1;
    if (own == 1 && s_if.bvalid) bid1_cap = m_if.bid[7:4];

    for (int i = 0; i < N; i++) begin
      hs_aw[i] = m_if.awvalid[i] && m_if.awready[i];
      hs_w[i]  = m_if.wvalid[i] && m_if.wready[i];
      hs_b[i]  = m_if.bvalid[i] && m_if.bready[i];
    end
    shs_w_last = s_if.wvalid && s_if.wready && s_if.wlast;
    shs_b      = s_if.bvalid && s_if.bready;

    if (s_if.wvalid && s_if.wready) begin
      sc_beats++;
      if (s_if.wlast) begin sc_last_cnt++; sc_last_idx = cur_len + 1 - beats_left; end
      if (own >= 0 && exp_q[own].size() > 0) chk("wbeat", s_if.wdata, exp_q[own].pop_front());
      else chk("wbeat_unexpected", 1, 0);
    end

    if (own < 0) begin
      if (|m_if.awvalid) begin
        own = rr_pick(m_if.awvalid, last_m);
        ph = 1;
        grant_log.push_back(own);
      end
    end else begin
      case (ph)
        1: if (m_if.awvalid[own] && s_if.awready) begin
          cur_len = int'(m_if.awlen[own*8 +: 8]);
          beats_left = cur_len + 1;
          ph = 2;
        end
        2: if (m_if.wvalid[own] && s_if.wready) begin
          if (m_if.wlast[own] != (beats_left == 1)) err_m = 1'b1;
          beats_left--;
          if (beats_left == 0) ph = 3;
        end
        default: if (s_if.bvalid && m_if.bready[own]) begin
          last_m = own;
          own = -1;
        end
      endcase
    end
  endtask

  // ---------------- drivers (posedge + 1) ----------------
  task automatic drive_step();
    logic [63:0] d;
    for (int i = 0; i < N; i++) begin
      case (mph[i])
        0: if (mpend[i] > 0 && urand(0, 99) < aw_rate) begin
          m_if.awvalid[i] = 1'b1;
          m_if.awaddr[i*32 +: 32] = $urandom;
          m_if.awid[i*4 +: 4] = 4'(urand(0, 15));
          mlen[i] = (len_force >= 0) ? len_force : urand(0, len_max);
          m_if.awlen[i*8 +: 8] = 8'(mlen[i]);
          m_if.awsize[i*3 +: 3] = 3'(urand(0, 3));
          m_if.awburst[i*2 +: 2] = 2'(urand(0, 2));
          mpend[i]--;
          mph[i] = 1;
        end
        1: if (hs_aw[i]) begin
          m_if.awvalid[i] = 1'b0;
          mbeat[i] = 0;
          mph[i] = 2;
        end
        2: if (hs_w[i]) begin
          m_if.wvalid[i] = 1'b0;
          m_if.wlast[i] = 1'b0;
          mbeat[i]++;
          if (mbeat[i] > mlen[i]) mph[i] = 3;
        end
        default: if (hs_b[i]) mph[i] = 0;
      endcase
      if (mph[i] == 2 && !m_if.wvalid[i] && urand(0, 99) < w_rate) begin
        d = {$urandom, $urandom};
        m_if.wvalid[i] = 1'b1;
        m_if.wdata[i*64 +: 64] = d;
        m_if.wstrb[i*8 +: 8] = 8'(urand(0, 255));
        m_if.wlast[i] = (mbeat[i] == mlen[i]) || (mbeat[i] == bad_beat);
        exp_q[i].push_back(d);
      end
      m_if.bready[i] = (urand(0, 99) < br_rate);
    end
    if (aw_stall > 0) begin s_if.awready = 1'b0; aw_stall--; end
    else s_if.awready = (urand(0, 99) < saw_rate);
    s_if.wready = w_toggle ? ~s_if.wready : (urand(0, 99) < sw_rate);
    if (shs_w_last) sb_pend = 1'b1;
    if (shs_b) begin s_if.bvalid = 1'b0; sb_pend = 1'b0; end
    if (sb_pend && !s_if.bvalid && urand(0, 99) < 60) begin
      s_if.bvalid = 1'b1;
      s_if.bresp = 2'(urand(0, 3));
      s_if.bid = use_bid ? force_bid : 4'(urand(0, 15));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    drive_step();
  endtask

  task automatic clear_bench();
    m_if.awvalid = '0; m_if.awaddr = '0; m_if.awid = '0; m_if.awlen = '0;
    m_if.awsize = '0; m_if.awburst = '0; m_if.wvalid = '0; m_if.wdata = '0;
    m_if.wstrb = '0; m_if.wlast = '0; m_if.bready = '0;
    s_if.awready = '0; s_if.wready = '0; s_if.bvalid = '0; s_if.bresp = '0; s_if.bid = '0;
    for (int i = 0; i < N; i++) begin
      mph[i] = 0; mpend[i] = 0; mlen[i] = 0; mbeat[i] = 0;
      hs_aw[i] = 0; hs_w[i] = 0; hs_b[i] = 0;
      exp_q[i].delete();
    end
    sb_pend = 0; shs_w_last = 0; shs_b = 0;
    own = -1; ph = 0; beats_left = 0; cur_len = 0; last_m = N - 1; err_m = 0;
    aw_rate = 100; w_rate = 100; br_rate = 100; saw_rate = 100; sw_rate = 100;
    len_force = -1; len_max = 7; bad_beat = -1; aw_stall = 0;
    w_toggle = 0; use_bid = 0; force_bid = 4'h0;
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks outputs before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", err_wlast, 0);
    chk("rst_m_awready", m_if.awready, 0);
    chk("rst_m_wready", m_if.wready, 0);
    chk("rst_m_bvalid", m_if.bvalid, 0);
    chk("rst_s_valids", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.wlast}, 0);
    clear_bench();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic clear_mon();
    sc_beats = 0; sc_last_cnt = 0; sc_last_idx = -1; viol1 = 0; bv0_cnt = 0;
    saw_bv0 = 0; saw_bv1 = 0; bid1_cap = 4'h0;
    grant_log.delete();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (mpend[i] != 0 || mph[i] != 0) return 0;
    return (own < 0) && !sb_pend && !s_if.bvalid;
  endfunction

  task automatic run(string name, int budget);
    int c;
    c = 0;
    while (!all_done() && c < budget) begin cycle(); c++; end
    if (c >= budget) chk({name, "_timeout"}, 1, 0);
    repeat (2) cycle();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    clear_bench();
    clear_mon();
    @(posedge clk);
    #1;
    do_reset();

    // Single write, len=3
    clear_mon();
    mpend[0] = 1; len_force = 3;
    run("single", 200);
    chk("single_beats", sc_beats, 4);
    chk("single_wlast_cnt", sc_last_cnt, 1);
    chk("single_wlast_idx", sc_last_idx, 3);
    chk("single_bvalid0", saw_bv0, 1);
    chk("single_err", err_wlast, 0);
    chk("single_busy_end", busy, 0);

    // Contention: both masters request continuously
    do_reset();
    clear_mon();
    mpend[0] = 2; mpend[1] = 2; len_force = 1;
    run("contend", 400);
    chk("contend_n", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("contend_g0", grant_log[0], 0);
      chk("contend_g1", grant_log[1], 1);
      chk("contend_g2", grant_log[2], 0);
      chk("contend_g3", grant_log[3], 1);
    end

    // Backpressure: AW stall and alternating wready
    do_reset();
    clear_mon();
    mpend[0] = 1; mpend[1] = 1; len_force = 7; aw_stall = 5; w_toggle = 1;
    run("bp", 400);
    chk("bp_beats", sc_beats, 16);
    chk("bp_m1_ready_while_m0", viol1, 0);
    chk("bp_order_n", grant_log.size(), 2);

    // Bad wlast on beat 2 of len=3
    do_reset();
    clear_mon();
    mpend[0] = 1; len_force = 3; bad_beat = 1;
    run("badwl", 200);
    chk("badwl_err", err_wlast, 1);
    chk("badwl_wlast_cnt", sc_last_cnt, 1);
    chk("badwl_wlast_idx", sc_last_idx, 3);
    repeat (5) cycle();
    chk("badwl_err_sticky", err_wlast, 1);

    // Randomized traffic
    do_reset();
    clear_mon();
    mpend[0] = 8; mpend[1] = 8;
    aw_rate = 60; w_rate = 70; br_rate = 50; saw_rate = 60; sw_rate = 65;
    run("rand", 5000);
    chk("rand_txns", grant_log.size(), 16);
    chk("rand_q0_empty", exp_q[0].size(), 0);
    chk("rand_q1_empty", exp_q[1].size(), 0);

    // Reset during DATA after 2 of 8 beats
    do_reset();
    clear_mon();
    mpend[0] = 1; len_force = 7;
    begin
      int c;
      c = 0;
      while (!(own == 0 && ph == 2 && beats_left == 6) && c < 100) begin cycle(); c++; end
      if (c >= 100) chk("rstdata_reach_timeout", 1, 0);
    end
    do_reset();
    clear_mon();
    mpend[0] = 1; mpend[1] = 1; len_force = 0;
    run("rstdata", 200);
    chk("rstdata_n", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("rstdata_first_grant", grant_log[0], 0);

    // B routing to master 1
    do_reset();
    clear_mon();
    mpend[1] = 1; len_force = 2; use_bid = 1; force_bid = 4'hA; br_rate = 50;
    run("broute", 300);
    chk("broute_bid1", bid1_cap, 4'hA);
    chk("broute_bvalid1", saw_bv1, 1);
    chk("broute_bvalid0", bv0_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
